// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: bus writes fill a TX FIFO that is serialised 8N1 on txd.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL bit1 selects odd parity).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hBFD0_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic [31:0] daddr,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    output logic        txd,
    output logic        irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e        state_q;
    logic [15:0]   baud_q, timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    data_q;
    logic          txd_q, irq_en_q, ovf_q;
    logic [31:0]   dm_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic        sel, is_wr, is_rd, push, push_ok, pop, ovf_clr;
    logic        full, empty, busy, par_odd;
    logic [1:0]  reg_sel;
    logic [7:0]  fifo_rdata;
    logic [31:0] rdata;
    logic        unused;

    assign sel     = dce & (daddr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = daddr[3:2];
    assign is_wr   = sel & (|we);
    assign is_rd   = dce & ~(|we);
    assign push    = is_wr & (reg_sel == 2'd0) & we[0];
    assign ovf_clr = is_wr & (reg_sel == 2'd1) & we[0] & din[3];
    assign unused  = ^{daddr[1:0], din[31:16], we[3:2]};

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign busy       = (state_q != StIdle);
    assign fifo_rdata = mem_q[rd_ptr_q];

    // The FSM takes a byte on leaving IDLE or on finishing a stop bit, keeping frames contiguous.
    always_comb begin
        pop     = ~empty & ((state_q == StIdle) | ((state_q == StStop) & (timer_q == '0)));
        push_ok = push & (~full | pop);
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (push_ok) mem_q[wr_ptr_q] <= din[7:0];
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok & ~pop)      count_q <= count_q + 1'b1;
            else if (~push_ok & pop) count_q <= count_q - 1'b1;
            // A fresh overflow beats a simultaneous clear.
            if (push & full & ~pop) ovf_q <= 1'b1;
            else if (ovf_clr)       ovf_q <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_odd_q;
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) par_odd_q <= 1'b0;
        else if (is_wr && reg_sel == 2'd3 && we[0]) par_odd_q <= din[1];
    end
    assign par_odd = par_odd_q;
`else
    assign par_odd = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd1:    rdata = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, busy};
            2'd2:    rdata = {16'h0, baud_q};
            2'd3:    rdata = {30'h0, par_odd, irq_en_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            baud_q   <= DIV_RESET;
            irq_en_q <= 1'b0;
            dm_q     <= '0;
        end else begin
            if (is_wr && reg_sel == 2'd2 && we[1:0] == 2'b11) baud_q <= din[15:0];
            if (is_wr && reg_sel == 2'd3 && we[0])            irq_en_q <= din[0];
            if (is_rd) dm_q <= sel ? rdata : '0;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q   <= StIdle;
            txd_q     <= 1'b1;
            timer_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StStart;
                        data_q  <= fifo_rdata;
                        timer_q <= baud_q;
                        txd_q   <= 1'b0;
                    end
                end
                StStart: begin
                    if (timer_q == '0) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        timer_q   <= baud_q;
                        txd_q     <= data_q[0];
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StData: begin
                    if (timer_q == '0) begin
                        timer_q <= baud_q;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= StParity;
                            txd_q   <= (^data_q) ^ par_odd;
`else
                            state_q <= StStop;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= data_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (timer_q == '0) begin
                        state_q <= StStop;
                        timer_q <= baud_q;
                        txd_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (timer_q == '0) begin
                        if (!empty) begin
                            state_q <= StStart;
                            data_q  <= fifo_rdata;
                            timer_q <= baud_q;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            txd_q   <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign dm  = dm_q;
    assign txd = txd_q;
    assign irq = irq_en_q & empty & ~busy;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx: a frame schedule model predicts txd and irq every cycle.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'hBFD0_0000;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] daddr = '0;
    logic        dce = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] din = '0;
    logic [31:0] dm;
    logic        txd, irq;

    mmio_uart_tx dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .txd         (txd),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: scheduled frames (start edge, byte, bit period) and config mirrors.
    int         f_start[$];
    int         f_per[$];
    logic [7:0] f_data[$];
    int         next_free = 0;
    int         div_m     = 433;
    logic       irq_en_m  = 1'b0;
    logic       par_odd_m = 1'b0;
    logic       chk_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (FB == 11 && idx == 9) return (^d) ^ par_odd_m;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_t;
            int   n;
            n = cyc;
            exp_t = 1'b1;
            for (int i = 0; i < f_start.size(); i++) begin
                if (n >= f_start[i] && n < f_start[i] + FB * f_per[i])
                    exp_t = frame_bit(f_data[i], (n - f_start[i]) / f_per[i]);
            end
            check("txd", txd, exp_t);
            check("irq", irq, irq_en_m && (n >= next_free));
        end
    end

    task automatic bus(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        daddr = a; dce = 1'b1; we = w; din = d;
        @(posedge clk);
        #1;
        dce = 1'b0; we = '0; din = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus(a, 4'b0000, 32'h0);
        check(tag, dm, exp);
    endtask

    task automatic set_cfg(input int div, input logic ien, input logic podd);
        bus(BASE + 32'h8, 4'b0011, div);
        div_m = div;
        bus(BASE + 32'hC, 4'b0001, {30'h0, podd, ien});
        irq_en_m = ien;
        if (FB == 11) par_odd_m = podd;
    endtask

    // A byte pushed on edge E starts at E+1, or right after the previous frame ends.
    task automatic push_byte(input logic [7:0] b);
        int st;
        bus(BASE, 4'b0001, {24'h0, b});
        st = (cyc + 1 > next_free) ? cyc + 1 : next_free;
        f_start.push_back(st);
        f_data.push_back(b);
        f_per.push_back(div_m + 1);
        next_free = st + FB * (div_m + 1);
    endtask

    task automatic drain();
        while (cyc < next_free + 2) @(posedge clk);
        #1;
        f_start.delete();
        f_data.delete();
        f_per.delete();
    endtask

    task automatic model_reset();
        next_free = cyc;
        div_m = 433;
        irq_en_m = 1'b0;
        par_odd_m = 1'b0;
        f_start.delete();
        f_data.delete();
        f_per.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, gap;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", txd, 1'b1);
        check("reset_irq", irq, 1'b0);
        rd(BASE + 32'h4, 32'h0000_0004, "reset_status");
        rd(BASE + 32'h8, 32'd433, "reset_baud");
        rd(BASE + 32'hC, 32'h0, "reset_ctrl");
        rd(BASE + 32'h0, 32'h0, "txdata_read");

        model_reset();
        chk_en = 1'b1;
        set_cfg(3, 1'b1, 1'b0);
        push_byte(8'hA5);
        rd(BASE + 32'h4, 32'h0000_0100, "status_pending");
        rd(BASE + 32'h4, 32'h0000_0005, "status_busy");
        drain();

        bus(BASE + 32'hC, 4'b0001, 32'h3);
        rd(BASE + 32'hC, (FB == 11) ? 32'h3 : 32'h1, "ctrl_readback");

        set_cfg(0, 1'b1, 1'b0);
        push_byte(8'h5A);
        push_byte(8'hC3);
        drain();

        for (int r = 0; r < 8; r++) begin
            set_cfg($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                gap = $urandom_range(0, 30);
                repeat (gap) @(posedge clk);
                push_byte(8'($urandom));
            end
            drain();
        end
        chk_en = 1'b0;

        bus(BASE + 32'h8, 4'b0011, 32'd100);
        for (int k = 0; k < 17; k++) bus(BASE, 4'b0001, k);
        rd(BASE + 32'h4, 32'h0000_1003, "status_full");
        bus(BASE, 4'b0001, 32'hEE);
        rd(BASE + 32'h4, 32'h0000_100B, "status_overflow");
        bus(BASE + 32'h4, 4'b0001, 32'h8);
        rd(BASE + 32'h4, 32'h0000_1003, "status_ovf_clear");

        repeat (200) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midframe_rst_txd", txd, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        rd(BASE + 32'h4, 32'h0000_0004, "midframe_rst_status");
        rd(BASE + 32'h8, 32'd433, "midframe_rst_baud");
        rd(BASE + 32'hC, 32'h0, "midframe_rst_ctrl");

        model_reset();
        chk_en = 1'b1;
        set_cfg(1, 1'b1, 1'b0);
        push_byte(8'h3C);
        drain();
        chk_en = 1'b0;

        bus(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);
        check("unsel_txd", txd, 1'b1);
        rd(BASE + 32'h8, 32'd1, "unsel_baud");
        rd(BASE + 32'h4, 32'h0000_0004, "unsel_status");
        rd(BASE + 32'hC, 32'h1, "unsel_ctrl");
        rd(BASE + 32'h14, 32'h0, "unsel_read");
        rd(BASE + 32'h8, 32'd1, "dm_load");
        repeat (3) @(posedge clk);
        #1;
        check("dm_hold", dm, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
